// File: rtl/sample_frame_packer.sv
// -----------------------------------------------------------------------------
// sample_frame_packer
//
// Packs per-channel sample words from the two AD7980 controllers (headstages
// A and B) into the byte-coded 16-bit word stream for the host-bound FIFO.
// Owns the 48-bit frame timecode, channel-0 frame alignment, start-up
// settling suppression, overrun accounting and FIFO back-pressure.
//
// Byte coding: data bytes carry bit 0 = 0, timecode bytes carry bit 0 = 1,
// so the host can re-align on any byte boundary.
//
// Ports
//   clk            in   AD_clk
//   reset          in   synchronous, active-high
//   data_ready     in   sample valid from controller A (rising edge = sample)
//   data_channel   in   [3:0] channel number of the current sample
//   data_word_a    in   [15:0] headstage A sample
//   data_word_b    in   [15:0] headstage B sample
//   data_ready_ack out  one-cycle pulse, clears data_ready in both controllers
//   fifo_din       out  [15:0] packed word, earlier byte in [7:0]
//   fifo_wr_en     out  FIFO write strobe
//   fifo_full      in   FIFO programmable-full (>= 2 free words when high)
//   timecode       out  [47:0] frame counter
//   overrun_count  out  [15:0] dropped samples, saturating
//   synced         out  high once a channel-0 frame start has been accepted
//
// Build option
//   PACKER_CHAN_TAG_EN  when defined, the ext bytes carry {headstage, channel}
//                       tags instead of zeros.
// -----------------------------------------------------------------------------
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a data_ready rising edge; sample latched on it
// CAPTURE   | ack pulse; channel 0 bumps timecode and (re)arms sync
// EMIT_TC   | three timecode words (channel 0 only)
// EMIT_DATA | three sample words, then back to IDLE
// -----------------------------------------------------------------------------
module sample_frame_packer #(
    parameter int NUM_CH      = 16,
    parameter int SKIP_FRAMES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_ready,
    input  logic [3:0]  data_channel,
    input  logic [15:0] data_word_a,
    input  logic [15:0] data_word_b,
    output logic        data_ready_ack,
    output logic [15:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic [47:0] timecode,
    output logic [15:0] overrun_count,
    output logic        synced
);

    generate
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
            $error("sample_frame_packer: NUM_CH must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        EMIT_TC,
        EMIT_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [47:0] tc_q, tc_d;
    logic [15:0] ovr_q, ovr_d;
    logic        synced_q, synced_d;
    logic        ovr_ack_q, ovr_ack_d;
    logic        dr_prev_q;
    logic        stall_q;
    logic [15:0] din_hold_q;
    logic [3:0]  ch_q;
    logic [15:0] a_q;
    logic [15:0] b_q;

    logic        dr_rise;
    logic        emitting;
    logic        advance;
    logic        suppress;
    logic        ack;
    logic [15:0] word;
    logic [4:0]  tag_a;
    logic [4:0]  tag_b;

`ifdef PACKER_CHAN_TAG_EN
    assign tag_a = {1'b0, ch_q};
    assign tag_b = {1'b1, ch_q};
`else
    assign tag_a = 5'b00000;
    assign tag_b = 5'b00000;
`endif

    // A level held high across cycles is one sample; only the edge counts.
    assign dr_rise  = data_ready & ~dr_prev_q;
    assign emitting = (state_q == EMIT_TC) || (state_q == EMIT_DATA);
    // fifo_full is registered, so a high sample blocks the word of the
    // following cycle; the word already on the bus fits in the 2-word margin.
    assign advance  = emitting & ~stall_q;
    assign suppress = (tc_q <= 48'(SKIP_FRAMES));
    assign ack      = (state_q == CAPTURE) | ovr_ack_q;

    always_comb begin
        word = 16'h0000;
        if (state_q == EMIT_TC) begin
            case (idx_q)
                2'd0:    word = {tc_q[13:7],  1'b1, tc_q[6:0],   1'b1};
                2'd1:    word = {tc_q[27:21], 1'b1, tc_q[20:14], 1'b1};
                2'd2:    word = {tc_q[41:35], 1'b1, tc_q[34:28], 1'b1};
                default: word = 16'h0000;
            endcase
        end else if (state_q == EMIT_DATA) begin
            case (idx_q)
                2'd0:    word = {a_q[7:1], 1'b0, a_q[15:9], 1'b0};
                2'd1:    word = {b_q[15:9], 1'b0, tag_a, a_q[8], a_q[0], 1'b0};
                2'd2:    word = {tag_b, b_q[8], b_q[0], 1'b0, b_q[7:1], 1'b0};
                default: word = 16'h0000;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tc_d      = tc_q;
        ovr_d     = ovr_q;
        synced_d  = synced_q;
        ovr_ack_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (dr_rise) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                idx_d = 2'd0;
                if (ch_q == 4'd0) begin
                    tc_d     = tc_q + 48'd1;
                    synced_d = 1'b1;
                    state_d  = EMIT_TC;
                end else if (synced_q) begin
                    state_d = EMIT_DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT_TC: begin
                if (advance) begin
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        state_d = EMIT_DATA;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            EMIT_DATA: begin
                if (advance) begin
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase

        // A sample arriving while busy is dropped but still acknowledged so
        // the controllers do not stall. Losing a channel 0 means the next
        // data words would have no timecode, so sync is dropped until the
        // next accepted channel 0.
        if (dr_rise && (state_q != IDLE)) begin
            if (ovr_q != 16'hFFFF) begin
                ovr_d = ovr_q + 16'd1;
            end
            ovr_ack_d = ~ack;
            if (data_channel == 4'd0) begin
                synced_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            tc_q       <= 48'd0;
            ovr_q      <= 16'd0;
            synced_q   <= 1'b0;
            ovr_ack_q  <= 1'b0;
            dr_prev_q  <= 1'b0;
            stall_q    <= 1'b0;
            din_hold_q <= 16'h0000;
            ch_q       <= 4'd0;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tc_q       <= tc_d;
            ovr_q      <= ovr_d;
            synced_q   <= synced_d;
            ovr_ack_q  <= ovr_ack_d;
            dr_prev_q  <= data_ready;
            stall_q    <= fifo_full;
            din_hold_q <= fifo_din;
            if ((state_q == IDLE) && dr_rise) begin
                ch_q <= data_channel;
                a_q  <= data_word_a;
                b_q  <= data_word_b;
            end
        end
    end

    assign fifo_wr_en     = advance & ~suppress;
    // Hold the last issued word while no write is in progress.
    assign fifo_din       = fifo_wr_en ? word : din_hold_q;
    assign data_ready_ack = ack;
    assign timecode       = tc_q;
    assign overrun_count  = ovr_q;
    assign synced         = synced_q;

endmodule

// File: tb/tb_sample_frame_packer.sv
module tb_sample_frame_packer;

    localparam bit TAG_EN =
`ifdef PACKER_CHAN_TAG_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_ready = 1'b0;
    logic [3:0]  data_channel = 4'd0;
    logic [15:0] data_word_a = 16'h0;
    logic [15:0] data_word_b = 16'h0;
    logic        fifo_full = 1'b0;

    logic        ack0, wr0, sync0;
    logic [15:0] din0, ovr0;
    logic [47:0] tc0;
    logic        ack_s, wr_s, sync_s;
    logic [15:0] din_s, ovr_s;
    logic [47:0] tc_s;

    sample_frame_packer #(.NUM_CH(16), .SKIP_FRAMES(0)) dut0 (
        .clk(clk), .reset(reset), .data_ready(data_ready),
        .data_channel(data_channel), .data_word_a(data_word_a),
        .data_word_b(data_word_b), .data_ready_ack(ack0), .fifo_din(din0),
        .fifo_wr_en(wr0), .fifo_full(fifo_full), .timecode(tc0),
        .overrun_count(ovr0), .synced(sync0)
    );

    sample_frame_packer dut_s (
        .clk(clk), .reset(reset), .data_ready(data_ready),
        .data_channel(data_channel), .data_word_a(data_word_a),
        .data_word_b(data_word_b), .data_ready_ack(ack_s), .fifo_din(din_s),
        .fifo_wr_en(wr_s), .fifo_full(fifo_full), .timecode(tc_s),
        .overrun_count(ovr_s), .synced(sync_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int s_cnt = 0;
    logic [15:0] sb[$];
    logic [15:0] cap[$];
    int          cap_cyc[$];
    logic [47:0] m_tc;
    logic        m_synced;

    typedef struct {
        logic [3:0]  ch;
        logic [15:0] a;
        logic [15:0] b;
        int          nwords;
        logic [15:0] first_data;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_tc(input logic [47:0] tc, input int j);
        logic [47:0] t;
        t = tc >> (14 * j);
        return {t[13:7], 1'b1, t[6:0], 1'b1};
    endfunction

    function automatic logic [15:0] exp_data(input logic [3:0] ch, input logic [15:0] a,
                                             input logic [15:0] b, input int j);
        logic [4:0] ta, tb;
        logic [7:0] ahi, alo, aext, bhi, blo, bext;
        ta   = {1'b0, ch} & {5{TAG_EN}};
        tb   = {1'b1, ch} & {5{TAG_EN}};
        ahi  = {a[15:9], 1'b0};
        alo  = {a[7:1], 1'b0};
        aext = {ta, a[8], a[0], 1'b0};
        bhi  = {b[15:9], 1'b0};
        blo  = {b[7:1], 1'b0};
        bext = {tb, b[8], b[0], 1'b0};
        case (j)
            0:       return {alo, ahi};
            1:       return {bhi, aext};
            default: return {bext, blo};
        endcase
    endfunction

    task automatic model_push(input logic [3:0] ch, input logic [15:0] a, input logic [15:0] b);
        if (ch == 4'd0) begin
            m_tc = m_tc + 48'd1;
            m_synced = 1'b1;
            for (int j = 0; j < 3; j++) sb.push_back(exp_tc(m_tc, j));
        end
        if (ch == 4'd0 || m_synced) begin
            for (int j = 0; j < 3; j++) sb.push_back(exp_data(ch, a, b, j));
        end
    endtask

    // Scoreboard side: every write of dut0 is compared against the model queue.
    always @(negedge clk) begin
        cyc++;
        if (ack0) ack_cnt++;
        if (wr_s) s_cnt++;
        if (wr0) begin
            cap.push_back(din0);
            cap_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %0h expected no write", din0);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (din0 !== e) begin
                    errors++;
                    $display("FAIL word: got %0h expected %0h", din0, e);
                end
            end
        end
    end

    task automatic send_sample(input logic [3:0] ch, input logic [15:0] a,
                               input logic [15:0] b, input int extra);
        int n;
        @(negedge clk);
        data_ready   = 1'b1;
        data_channel = ch;
        data_word_a  = a;
        data_word_b  = b;
        model_push(ch, a, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack0 && n < 4);
        check("ack", 64'(ack0), 64'd1);
        data_ready = 1'b0;
        repeat (((ch == 4'd0) ? 8 : 5) + extra) @(negedge clk);
    endtask

    task automatic reset_all();
        @(negedge clk);
        reset      = 1'b1;
        data_ready = 1'b0;
        fifo_full  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        cap.delete();
        cap_cyc.delete();
        m_tc = 48'd0;
        m_synced = 1'b0;
    endtask

    initial begin
        int n, acks0;
        vecs[0] = '{4'd0,  16'hA5C3, 16'h0F0F, 6, 16'hC2A4};
        vecs[1] = '{4'd1,  16'hFFFF, 16'h0000, 3, 16'hFEFE};
        vecs[2] = '{4'd2,  16'h0000, 16'hFFFF, 3, 16'h0000};
        vecs[3] = '{4'd15, 16'h1234, 16'h8000, 3, 16'h3412};
        vecs[4] = '{4'd0,  16'h8001, 16'h7FFE, 6, 16'h0080};
        vecs[5] = '{4'd1,  16'h00FF, 16'hFF00, 3, 16'hFE00};

        // reset state
        reset_all();
        check("rst_wr_en", 64'(wr0), 64'd0);
        check("rst_din", 64'(din0), 64'd0);
        check("rst_ack", 64'(ack0), 64'd0);
        check("rst_timecode", 64'(tc0), 64'd0);
        check("rst_overrun", 64'(ovr0), 64'd0);
        check("rst_synced", 64'(sync0), 64'd0);

        // reset in the middle of a frame abandons it
        @(negedge clk);
        data_ready = 1'b1; data_channel = 4'd0; data_word_a = 16'h1357; data_word_b = 16'h2468;
        model_push(4'd0, 16'h1357, 16'h2468);
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        check("midrst_first_wr", 64'(wr0), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wr_en", 64'(wr0), 64'd0);
        check("midrst_timecode", 64'(tc0), 64'd0);
        check("midrst_synced", 64'(sync0), 64'd0);
        check("midrst_din", 64'(din0), 64'd0);
        reset_all();

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            cap.delete();
            send_sample(vecs[i].ch, vecs[i].a, vecs[i].b, 0);
            check("nwords", 64'(cap.size()), 64'(vecs[i].nwords));
            if (cap.size() == vecs[i].nwords)
                check("first_data", 64'(cap[vecs[i].nwords - 3]), 64'(vecs[i].first_data));
        end
        check("tbl_timecode", 64'(tc0), 64'd2);
        check("tbl_synced", 64'(sync0), 64'd1);
        check("tbl_first_tc_word", 64'(exp_tc(48'd1, 0)), 64'h0103);

        // back-pressure for 10 cycles after the first timecode word
        cap.delete();
        cap_cyc.delete();
        fork
            send_sample(4'd0, 16'h5A5A, 16'hC3C3, 12);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!wr0 && n < 20);
                check("bp_first_write", 64'(wr0), 64'd1);
                fifo_full = 1'b1;
                repeat (10) @(posedge clk);
                #1 fifo_full = 1'b0;
            end
        join
        check("bp_nwords", 64'(cap.size()), 64'd6);
        if (cap_cyc.size() == 6)
            check("bp_span", 64'(cap_cyc[5] - cap_cyc[0]), 64'd15);

        // overrun during EMIT_TC of channel 0
        reset_all();
        cap.delete();
        acks0 = ack_cnt;
        @(negedge clk);
        data_ready = 1'b1; data_channel = 4'd0; data_word_a = 16'h1111; data_word_b = 16'h2222;
        model_push(4'd0, 16'h1111, 16'h2222);
        @(negedge clk);
        check("ovr_ack", 64'(ack0), 64'd1);
        data_ready = 1'b0;
        @(negedge clk);
        data_ready = 1'b1; data_channel = 4'd0; data_word_a = 16'hFFFF; data_word_b = 16'hFFFF;
        m_synced = 1'b0;
        @(negedge clk);
        data_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("ovr_count", 64'(ovr0), 64'd1);
        check("ovr_synced", 64'(sync0), 64'd0);
        check("ovr_frame_words", 64'(cap.size()), 64'd6);
        check("ovr_acks", 64'(ack_cnt - acks0), 64'd2);
        cap.delete();
        for (int c = 1; c < 16; c++) send_sample(4'(c), 16'(c * 257), 16'(c * 4369), 0);
        check("ovr_unsynced_words", 64'(cap.size()), 64'd0);
        send_sample(4'd0, 16'hBEEF, 16'hCAFE, 0);
        check("ovr_resync_words", 64'(cap.size()), 64'd6);
        check("ovr_resynced", 64'(sync0), 64'd1);

        // start mid-frame at channel 5
        reset_all();
        cap.delete();
        acks0 = ack_cnt;
        for (int c = 5; c < 16; c++) send_sample(4'(c), 16'(c), 16'(~c), 0);
        check("ch5_words", 64'(cap.size()), 64'd0);
        check("ch5_acks", 64'(ack_cnt - acks0), 64'd11);
        send_sample(4'd0, 16'h0F0F, 16'hF0F0, 0);
        check("ch5_ch0_words", 64'(cap.size()), 64'd6);

        // settling suppression on the default-parameter instance
        reset_all();
        s_cnt = 0;
        for (int f = 1; f <= 258; f++) begin
            for (int c = 0; c < 16; c++) send_sample(4'(c), 16'(f * 16 + c), 16'(~(f * 16 + c)), 0);
            if (f == 256) check("skip_none_256", 64'(s_cnt), 64'd0);
            if (f == 257) check("skip_frame_257", 64'(s_cnt), 64'd51);
            if (f == 258) check("skip_frame_258", 64'(s_cnt), 64'd102);
        end
        check("skip_timecode", 64'(tc_s), 64'd258);
        check("skip_overrun", 64'(ovr_s), 64'd0);

        repeat (4) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
